// File: rtl/lab61soc_pio_pkg.sv
// Shared register addresses, edge-mode encodings and the edge-qualify helper
// for the button interrupt PIO.
package lab61soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RAW     = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(input int mode, input logic old_level, input logic new_level);
    logic hit;
    hit = 1'b0;
    case (mode)
      EDGE_RISE: hit = !old_level && new_level;
      EDGE_FALL: hit = old_level && !new_level;
      default:   hit = old_level != new_level;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/lab61soc_debounce_bit.sv
// One input channel: synchroniser chain, debounce counter, accepted stable level
// and a one-cycle pulse when the stable level makes a qualifying transition.
module lab61soc_debounce_bit
  import lab61soc_pio_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DEBOUNCE    = 50000,
  parameter int   EDGE_MODE   = 1,
  parameter logic INIT_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic raw,
  output logic stable,
  output logic edge_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;

  assign raw = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // The edge pulse is registered together with the stable update so the
  // capture register sees it exactly one clock after the level is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable     <= INIT_LEVEL;
      cnt        <= '0;
      edge_pulse <= 1'b0;
    end else begin
      edge_pulse <= 1'b0;
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        stable     <= raw;
        cnt        <= '0;
        edge_pulse <= edge_hit(EDGE_MODE, stable, raw);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lab61soc_button_irq_pio.sv
// Avalon-MM input PIO for push-buttons: per-channel debounce, edge capture
// with write-one-to-clear, per-bit interrupt mask and a level IRQ.
module lab61soc_button_irq_pio
  import lab61soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               DEBOUNCE    = 50000,
  parameter int               EDGE_MODE   = 1,
  parameter logic [WIDTH-1:0] INIT_LEVEL  = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_next;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    lab61soc_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE),
      .EDGE_MODE  (EDGE_MODE),
      .INIT_LEVEL (INIT_LEVEL[i])
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .din       (in_port[i]),
      .raw       (raw[i]),
      .stable    (stable[i]),
      .edge_pulse(edges[i])
    );
  end

  assign wr           = chipselect && !write_n;
  assign clear_bits   = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_RAW:     rd_next[WIDTH-1:0] = raw;
      ADDR_MASK:    rd_next[WIDTH-1:0] = mask;
      default:      rd_next[WIDTH-1:0] = capture;
    endcase
  end

  // New edges are OR-ed in after the clear so a same-cycle W1C cannot lose an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask     <= '0;
      capture  <= '0;
      readdata <= '0;
    end else begin
      if (wr && address == ADDR_MASK) begin
        mask <= writedata[WIDTH-1:0];
      end
      capture  <= (capture & ~clear_bits) | edges;
      readdata <= rd_next;
    end
  end

  assign irq = |(capture & mask);

endmodule

// File: tb/tb_lab61soc_button_irq_pio.sv
// Directed self-checking bench for the button IRQ PIO (WIDTH=4, DEBOUNCE=4,
// SYNC_STAGES=2, falling-edge capture, keys idle high).
module tb_lab61soc_button_irq_pio;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks_total  = 0;
  int checks_passed = 0;

  lab61soc_button_irq_pio #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .DEBOUNCE   (4),
    .EDGE_MODE  (1),
    .INIT_LEVEL (4'hF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; the write is sampled at the next rising edge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    writedata  = data;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
    address = addr;
    tick(1);
    data = readdata;
  endtask

  logic [31:0] rd;
  int          low_cycles;

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 4'hF;
    tick(3);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;

    // 1: register map after reset
    readReg(2'd0, rd); checkOutput("t1_data", rd, 32'h0000_000F);
    readReg(2'd1, rd); checkOutput("t1_raw", rd, 32'h0000_000F);
    readReg(2'd2, rd); checkOutput("t1_mask", rd, 32'h0000_0000);
    readReg(2'd3, rd); checkOutput("t1_capture", rd, 32'h0000_0000);
    checkOutput("t1_irq", {31'b0, irq}, 32'h0);

    // 2: key0 pressed and held; accepted after 2 sync + 4 debounce clocks
    address = 2'd0;
    in_port = 4'hE;
    tick(6);
    checkOutput("t2_data_early", readdata, 32'h0000_000F);
    tick(1);
    checkOutput("t2_data", readdata, 32'h0000_000E);
    readReg(2'd3, rd); checkOutput("t2_capture", rd, 32'h0000_0001);
    checkOutput("t2_irq_masked", {31'b0, irq}, 32'h0);

    // 3: unmask, then W1C
    applyStimulus(2'd2, 32'h1);
    checkOutput("t3_irq_set", {31'b0, irq}, 32'h1);
    readReg(2'd2, rd); checkOutput("t3_mask", rd, 32'h0000_0001);
    applyStimulus(2'd3, 32'h1);
    checkOutput("t3_irq_clr", {31'b0, irq}, 32'h0);
    readReg(2'd3, rd); checkOutput("t3_capture", rd, 32'h0000_0000);

    // 4: 3-clock glitch on key2 is visible on RAW but rejected
    address    = 2'd1;
    in_port    = 4'hA;
    low_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) in_port = 4'hE;
      tick(1);
      if (readdata == 32'h0000_000A) low_cycles++;
    end
    checkOutput("t4_raw_pulse", low_cycles, 32'd3);
    readReg(2'd0, rd); checkOutput("t4_data", rd, 32'h0000_000E);
    readReg(2'd3, rd); checkOutput("t4_capture", rd, 32'h0000_0000);

    // 5: W1C of bit1 lands in the same clock its edge sets the capture bit
    applyStimulus(2'd2, 32'h3);
    in_port = 4'hC;
    tick(6);
    applyStimulus(2'd3, 32'h2);
    checkOutput("t5_irq", {31'b0, irq}, 32'h1);
    readReg(2'd3, rd); checkOutput("t5_capture", rd, 32'h0000_0002);
    applyStimulus(2'd3, 32'h2);
    checkOutput("t5_irq_clr", {31'b0, irq}, 32'h0);

    // 6: reset in the middle of a debounce count on key3
    in_port = 4'h4;
    tick(3);
    reset   = 1'b1;
    in_port = 4'hF;
    tick(2);
    checkOutput("t6_readdata", readdata, 32'h0);
    checkOutput("t6_irq", {31'b0, irq}, 32'h0);
    reset = 1'b0;
    readReg(2'd0, rd); checkOutput("t6_data", rd, 32'h0000_000F);
    readReg(2'd1, rd); checkOutput("t6_raw", rd, 32'h0000_000F);
    readReg(2'd2, rd); checkOutput("t6_mask", rd, 32'h0000_0000);
    tick(10);
    readReg(2'd3, rd); checkOutput("t6_capture", rd, 32'h0000_0000);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
